// File: rtl/dma_mc_engine.sv
// dma_mc_engine: round-robin multi-channel DMA feeding one read/compute/write sequencer.
// Define DMA_CHECKSUM_EN to add ch_csum, the XOR of every word written by the last transfer.
module dma_mc_engine #(
   parameter int NUM_CH    = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int LEN_W     = 16,
   parameter int MAX_BURST = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        ch_start,
   input  logic [NUM_CH*ADDR_W-1:0] ch_task_addr,
   output logic [NUM_CH-1:0]        ch_done,
   output logic                     busy,
   output logic                     rd_req,
   output logic [ADDR_W-1:0]        rd_addr,
   input  logic                     rd_grant,
   input  logic [DATA_W-1:0]        rd_data,
   output logic                     wr_req,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   input  logic                     wr_grant
`ifdef DMA_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0]        ch_csum
`endif
);
   localparam int CW = $clog2(MAX_BURST);
   localparam int PW = $clog2(NUM_CH);
   typedef enum logic [2:0] {
      DMA_IDLE, DMA_PENDING, DMA_TASK_READ, DMA_DATA_READ, DMA_COMPUTE, DMA_WRITING
   } state_t;
   state_t state_q, state_d;
   logic [NUM_CH-1:0] pending_q, pending_d, done_q, done_d;
   logic [PW-1:0] rr_q, rr_d, ch_q, ch_d, gnt, idx;
   logic gnt_vld;
   logic [1:0] tidx_q, tidx_d;
   logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic [LEN_W-1:0] rem_q, rem_d, rem_left;
   logic [CW:0] beat_q, beat_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic rd_req_q, rd_req_d, wr_req_q, wr_req_d, busy_q, busy_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [DATA_W-1:0] dbuf_q [MAX_BURST];
   logic [DATA_W-1:0] dbuf_d [MAX_BURST];
   logic rd_hs, wr_hs, last_beat;

   function automatic logic [CW:0] clip(input logic [LEN_W-1:0] n);
      return (n >= LEN_W'(MAX_BURST)) ? (CW+1)'(MAX_BURST) : n[CW:0];
   endfunction

   assign rd_hs     = rd_req_q & rd_grant;
   assign wr_hs     = wr_req_q & wr_grant;
   assign last_beat = {1'b0, cnt_q} == beat_q - 1'b1;
   assign rem_left  = rem_q - LEN_W'(beat_q);

   // Scan downwards so the first pending channel at or after rr_q wins.
   always_comb begin
      gnt = '0;
      gnt_vld = 1'b0;
      idx = '0;
      for (int k = NUM_CH-1; k >= 0; k--) begin
         idx = PW'((int'(rr_q) + k) % NUM_CH);
         if (pending_q[idx]) begin
            gnt = idx;
            gnt_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pending_d = pending_q | ch_start;
      rr_d = rr_q;
      ch_d = ch_q;
      tidx_d = tidx_q;
      src_d = src_q;
      dst_d = dst_q;
      rem_d = rem_q;
      beat_d = beat_q;
      cnt_d = cnt_q;
      rd_req_d = rd_req_q;
      rd_addr_d = rd_addr_q;
      wr_req_d = wr_req_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d = '0;
      dbuf_d = dbuf_q;
      case (state_q)
         DMA_IDLE: if (|pending_d) state_d = DMA_PENDING;
         DMA_PENDING: begin
            if (gnt_vld) begin
               pending_d[gnt] = ch_start[gnt];
               ch_d = gnt;
               rr_d = (int'(gnt) == NUM_CH-1) ? '0 : gnt + 1'b1;
               rd_req_d = 1'b1;
               rd_addr_d = ch_task_addr[gnt*ADDR_W +: ADDR_W];
               tidx_d = '0;
               state_d = DMA_TASK_READ;
            end else state_d = DMA_IDLE;
         end
         DMA_TASK_READ: if (rd_hs) begin
            rd_addr_d = rd_addr_q + 1'b1;
            tidx_d = tidx_q + 1'b1;
            if (tidx_q == 2'd0) src_d = ADDR_W'(rd_data);
            if (tidx_q == 2'd1) dst_d = ADDR_W'(rd_data);
            if (tidx_q == 2'd2) begin
               rem_d = LEN_W'(rd_data);
               beat_d = clip(LEN_W'(rd_data));
               cnt_d = '0;
               rd_addr_d = src_q;
               if (LEN_W'(rd_data) == '0) begin
                  rd_req_d = 1'b0;
                  done_d[ch_q] = 1'b1;
                  state_d = DMA_IDLE;
               end else state_d = DMA_DATA_READ;
            end
         end
         DMA_DATA_READ: if (rd_hs) begin
            dbuf_d[cnt_q] = rd_data;
            src_d = src_q + 1'b1;
            rd_addr_d = src_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (last_beat) begin
               rd_req_d = 1'b0;
               state_d = DMA_COMPUTE;
            end
         end
         DMA_COMPUTE: begin
            wr_req_d = 1'b1;
            wr_addr_d = dst_q;
            wr_data_d = dbuf_q[0];
            cnt_d = '0;
            state_d = DMA_WRITING;
         end
         DMA_WRITING: if (wr_hs) begin
            dst_d = dst_q + 1'b1;
            wr_addr_d = dst_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
            wr_data_d = dbuf_q[cnt_q + 1'b1];
            if (last_beat) begin
               wr_req_d = 1'b0;
               rem_d = rem_left;
               beat_d = clip(rem_left);
               cnt_d = '0;
               if (rem_left == '0) begin
                  done_d[ch_q] = 1'b1;
                  state_d = DMA_IDLE;
               end else begin
                  rd_req_d = 1'b1;
                  rd_addr_d = src_q;
                  state_d = DMA_DATA_READ;
               end
            end
         end
         default: state_d = DMA_IDLE;
      endcase
      busy_d = state_d != DMA_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= DMA_IDLE;
         pending_q <= '0;
         done_q <= '0;
         rr_q <= '0;
         ch_q <= '0;
         tidx_q <= '0;
         src_q <= '0;
         dst_q <= '0;
         rem_q <= '0;
         beat_q <= '0;
         cnt_q <= '0;
         rd_req_q <= 1'b0;
         rd_addr_q <= '0;
         wr_req_q <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pending_q <= pending_d;
         done_q <= done_d;
         rr_q <= rr_d;
         ch_q <= ch_d;
         tidx_q <= tidx_d;
         src_q <= src_d;
         dst_q <= dst_d;
         rem_q <= rem_d;
         beat_q <= beat_d;
         cnt_q <= cnt_d;
         rd_req_q <= rd_req_d;
         rd_addr_q <= rd_addr_d;
         wr_req_q <= wr_req_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q <= busy_d;
      end
   end

   always_ff @(posedge clk) dbuf_q <= dbuf_d;

   assign ch_done = done_q;
   assign busy    = busy_q;
   assign rd_req  = rd_req_q;
   assign rd_addr = rd_addr_q;
   assign wr_req  = wr_req_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

`ifdef DMA_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;
   // Folded once per round while the buffer is stable in COMPUTE.
   always_comb begin
      csum_d = (state_q == DMA_PENDING) ? '0 : csum_q;
      if (state_q == DMA_COMPUTE)
         for (int i = 0; i < MAX_BURST; i++)
            if (i < int'(beat_q)) csum_d = csum_d ^ dbuf_q[i];
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) csum_q <= '0;
      else csum_q <= csum_d;
   end
   assign ch_csum = csum_q;
`endif
endmodule

// File: tb/tb_dma_mc_engine.sv
// tb_dma_mc_engine: directed table-driven bench for dma_mc_engine with a behavioural memory.
module tb_dma_mc_engine;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] ch_start = '0;
   logic [127:0] ch_task_addr;
   logic [3:0] ch_done;
   logic busy, rd_req, rd_grant, wr_req, wr_grant;
   logic [31:0] rd_addr, rd_data, wr_addr, wr_data;
`ifdef DMA_CHECKSUM_EN
   logic [31:0] ch_csum;
`endif
   logic [31:0] d_src [4];
   logic [31:0] d_dst [4];
   logic [15:0] d_len [4];
   logic [31:0] rd_log [$];
   logic [31:0] wa_log [$];
   logic [31:0] wd_log [$];
   int done_q [$];
   int gaps;
   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      int ch;
      logic [31:0] src;
      logic [31:0] dst;
      logic [15:0] len;
      int gaps;
      int nwr;
      logic [31:0] last;
   } vec_t;
   vec_t vt [7];

   assign ch_task_addr = {32'h1030, 32'h1020, 32'h1010, 32'h1000};

   dma_mc_engine dut (
      .clk(clk), .reset(reset), .ch_start(ch_start), .ch_task_addr(ch_task_addr),
      .ch_done(ch_done), .busy(busy), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_grant(rd_grant), .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_grant(wr_grant)
`ifdef DMA_CHECKSUM_EN
      , .ch_csum(ch_csum)
`endif
   );

   always #5 clk = ~clk;

   // Descriptors live at 0x1000 + 16*ch; a few words near address 0 hold the wrap pattern.
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      if (a[31:6] == 26'h40 && a[3:0] == 4'd0) return d_src[a[5:4]];
      if (a[31:6] == 26'h40 && a[3:0] == 4'd1) return d_dst[a[5:4]];
      if (a[31:6] == 26'h40 && a[3:0] == 4'd2) return {16'hBEEF, d_len[a[5:4]]};
      if (a == 32'hFFFF_FFFE) return 32'h1;
      if (a == 32'hFFFF_FFFF) return 32'h2;
      if (a == 32'h0) return 32'h4;
      if (a == 32'h1) return 32'h8;
      return {~a[15:0], a[15:0]};
   endfunction

   always @(negedge clk) begin
      rd_data = mem_f(rd_addr);
      if (rd_req && rd_grant) rd_log.push_back(rd_addr);
      if (wr_req && wr_grant) begin
         wa_log.push_back(wr_addr);
         wd_log.push_back(wr_data);
      end
      if (busy && !rd_req && !wr_req) gaps++;
      for (int i = 0; i < 4; i++) if (ch_done[i]) done_q.push_back(i);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      rd_log.delete();
      wa_log.delete();
      wd_log.delete();
      done_q.delete();
      gaps = 0;
   endtask

   task automatic wait_done(input int n);
      int t = 0;
      while (done_q.size() < n && t < 3000) begin
         tick();
         t++;
      end
      if (done_q.size() < n) check("done_timeout", done_q.size(), n);
   endtask

   task automatic run_xfer(input int ch, input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] l);
      d_src[ch] = s;
      d_dst[ch] = d;
      d_len[ch] = l;
      clear_logs();
      ch_start = 4'b1 << ch;
      tick();
      ch_start = '0;
      wait_done(1);
      repeat (3) tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t;
      int bad;
      logic [31:0] x;
      vt[0] = '{0, 32'h100,        32'h200,        16'd3,  2, 3,  32'h202};
      vt[1] = '{2, 32'h300,        32'h400,        16'd20, 4, 20, 32'h413};
      vt[2] = '{1, 32'h500,        32'h600,        16'd8,  2, 8,  32'h607};
      vt[3] = '{3, 32'h700,        32'h800,        16'd9,  3, 9,  32'h808};
      vt[4] = '{2, 32'h10,         32'hFFFF_FFFF,  16'd2,  2, 2,  32'h0};
      vt[5] = '{1, 32'h40,         32'h50,         16'd0,  1, 0,  32'h0};
      vt[6] = '{0, 32'hFFFF_FFFE,  32'h900,        16'd4,  2, 4,  32'h903};
      for (int i = 0; i < 4; i++) begin
         d_src[i] = '0;
         d_dst[i] = '0;
         d_len[i] = '0;
      end
      rd_grant = 1'b1;
      wr_grant = 1'b1;
      clear_logs();
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst_busy", busy, 0);
      check("rst_rd_req", rd_req, 0);
      check("rst_wr_req", wr_req, 0);
      check("rst_done", ch_done, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_wr_addr", wr_addr, 0);

      // Reset while ch1 is writing: transfer abandoned silently.
      d_src[1] = 32'hA00;
      d_dst[1] = 32'hB00;
      d_len[1] = 16'd5;
      clear_logs();
      ch_start = 4'b0010;
      tick();
      ch_start = '0;
      t = 0;
      while (!wr_req && t < 200) begin
         tick();
         t++;
      end
      check("reach_writing", wr_req, 1);
      tick();
      reset = 1'b1;
      #1;
      check("midrst_rd_req", rd_req, 0);
      check("midrst_wr_req", wr_req, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", ch_done, 0);
      tick();
      reset = 1'b0;
      repeat (20) tick();
      check("midrst_no_done", done_q.size(), 0);
      check("midrst_stay_idle", busy, 0);

      // Simultaneous starts, then rr pointer at 1 with ch2+ch0.
      for (int i = 0; i < 4; i++) begin
         d_src[i] = 32'h2000 + 32'h100 * i;
         d_dst[i] = 32'h3000 + 32'h100 * i;
         d_len[i] = 16'd2;
      end
      clear_logs();
      ch_start = 4'hF;
      tick();
      ch_start = '0;
      wait_done(4);
      for (int i = 0; i < 4; i++) check("rr_order_all", done_q[i], i);
      repeat (3) tick();
      run_xfer(0, 32'h2000, 32'h3000, 16'd1);
      clear_logs();
      ch_start = 4'b0101;
      tick();
      ch_start = '0;
      wait_done(2);
      check("rr_order_a", done_q[0], 2);
      check("rr_order_b", done_q[1], 0);
      repeat (3) tick();

      // Start latency and a stalled descriptor read with len=0.
      d_src[3] = 32'h777;
      d_dst[3] = 32'h888;
      d_len[3] = 16'd0;
      rd_grant = 1'b0;
      clear_logs();
      ch_start = 4'b1000;
      tick();
      ch_start = '0;
      check("lat_cycle1_rd_req", rd_req, 0);
      tick();
      check("lat_cycle2_rd_req", rd_req, 1);
      check("lat_cycle2_rd_addr", rd_addr, 32'h1030);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rd_req !== 1'b1 || rd_addr !== 32'h1030) bad++;
      end
      check("stall_stable", bad, 0);
      rd_grant = 1'b1;
      wait_done(1);
      repeat (3) tick();
      check("len0_reads", rd_log.size(), 3);
      check("len0_writes", wa_log.size(), 0);
      check("len0_done_ch", done_q[0], 3);
      check("len0_gaps", gaps, 1);

      for (int v = 0; v < 7; v++) begin
         run_xfer(vt[v].ch, vt[v].src, vt[v].dst, vt[v].len);
         check("vec_done_cnt", done_q.size(), 1);
         check("vec_done_ch", done_q[0], vt[v].ch);
         check("vec_gaps", gaps, vt[v].gaps);
         check("vec_nwr", wa_log.size(), vt[v].nwr);
         check("vec_nrd", rd_log.size(), vt[v].nwr + 3);
         check("vec_busy", busy, 0);
         if (vt[v].nwr > 0) check("vec_last_wr", wa_log[wa_log.size()-1], vt[v].last);
         bad = 0;
         x = '0;
         for (int i = 0; i < 3; i++)
            if (rd_log[i] !== 32'h1000 + 32'h10 * vt[v].ch + i) bad++;
         for (int i = 0; i < vt[v].nwr; i++) begin
            if (rd_log[3+i] !== vt[v].src + i) bad++;
            if (wa_log[i] !== vt[v].dst + i) bad++;
            if (wd_log[i] !== mem_f(vt[v].src + i)) bad++;
            x = x ^ mem_f(vt[v].src + i);
         end
         check("vec_traffic", bad, 0);
`ifdef DMA_CHECKSUM_EN
         check("vec_csum", ch_csum, x);
`endif
      end
      check("wrap_rd0", rd_log[3], 32'hFFFF_FFFE);
      check("wrap_rd1", rd_log[4], 32'hFFFF_FFFF);
      check("wrap_rd2", rd_log[5], 32'h0);
      check("wrap_rd3", rd_log[6], 32'h1);
`ifdef DMA_CHECKSUM_EN
      check("wrap_csum", ch_csum, 32'hF);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
